// File: rtl/cache_way_param_pkg.sv
// rtl/cache_way_param_pkg.sv - shared types and default geometry for the parametrised cache way
package cache_way_param_pkg;

   localparam int L1_SETS   = 8;
   localparam int L1_TAG_W  = 9;
   localparam int L1_LINE_W = 128;

   typedef struct packed {
      logic write_data;
      logic write_tag;
      logic write_dirty;
      logic inval_one;
   } cache_way_cmd_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      WB   = 2'd2,
      DONE = 2'd3
   } flush_state_t;

endpackage

// File: rtl/cache_way_param_if.sv
// rtl/cache_way_param_if.sv - access, flush and write-back signal bundle of one cache way
interface cache_way_param_if
   import cache_way_param_pkg::*;
#(
   parameter int SETS   = L1_SETS,
   parameter int TAG_W  = L1_TAG_W,
   parameter int LINE_W = L1_LINE_W
);
   localparam int IDX_W = $clog2(SETS);
   localparam int BE_W  = LINE_W / 8;

   logic [IDX_W-1:0]  index;
   logic [TAG_W-1:0]  tag_in;
   logic [LINE_W-1:0] data_in;
   logic [BE_W-1:0]   byte_en;
   logic              write_data;
   logic              write_tag;
   logic              write_dirty;
   logic              dirty_in;
   logic              inval_one;
   logic              flush_req;
   logic              wb_ack;

   logic              valid_out;
   logic              dirty_out;
   logic [TAG_W-1:0]  tag_out;
   logic [LINE_W-1:0] data_out;
   logic              hit;
   logic              flush_busy;
   logic              flush_done;
   logic              wb_valid;
   logic [IDX_W-1:0]  wb_index;
   logic [TAG_W-1:0]  wb_tag;
   logic [LINE_W-1:0] wb_data;

   modport master (
      output index, tag_in, data_in, byte_en, write_data, write_tag,
             write_dirty, dirty_in, inval_one, flush_req, wb_ack,
      input  valid_out, dirty_out, tag_out, data_out, hit, flush_busy,
             flush_done, wb_valid, wb_index, wb_tag, wb_data
   );

   modport slave (
      input  index, tag_in, data_in, byte_en, write_data, write_tag,
             write_dirty, dirty_in, inval_one, flush_req, wb_ack,
      output valid_out, dirty_out, tag_out, data_out, hit, flush_busy,
             flush_done, wb_valid, wb_index, wb_tag, wb_data
   );

endinterface

// File: rtl/cache_way_param_bytewrite_array.sv
// rtl/cache_way_param_bytewrite_array.sv - SETS x LINE_W data store, byte-enable write, two async read ports
module way_bytewrite_array #(
   parameter int  SETS   = 8,
   parameter int  LINE_W = 128,
   localparam int IDX_W  = $clog2(SETS),
   localparam int BE_W   = LINE_W / 8
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  widx_i,
   input  logic [LINE_W-1:0] wdata_i,
   input  logic [BE_W-1:0]   wbe_i,
   input  logic [IDX_W-1:0]  ridx_a_i,
   output logic [LINE_W-1:0] rdata_a_o,
   input  logic [IDX_W-1:0]  ridx_b_i,
   output logic [LINE_W-1:0] rdata_b_o
);

   logic [LINE_W-1:0] mem_q [SETS];

   // Byte-gated write; contents are not reset, the way's valid bits qualify them
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int k = 0; k < BE_W; k++) begin
            if (wbe_i[k]) begin
               mem_q[widx_i][8*k +: 8] <= wdata_i[8*k +: 8];
            end
         end
      end
   end

   // Port A serves the access index, port B the flush pointer
   assign rdata_a_o = mem_q[ridx_a_i];
   assign rdata_b_o = mem_q[ridx_b_i];

endmodule

// File: rtl/cache_way_param.sv
// rtl/cache_way_param.sv - one cache way: storage, hit compare, invalidate and flush/write-back engine
module cache_way_param
   import cache_way_param_pkg::*;
#(
   parameter int SETS   = L1_SETS,
   parameter int TAG_W  = L1_TAG_W,
   parameter int LINE_W = L1_LINE_W
) (
   input  logic            clk,
   input  logic            rst_n,
   cache_way_param_if.slave bus
);

   localparam int               IDX_W    = $clog2(SETS);
   localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

   flush_state_t      state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [SETS-1:0]   valid_q, valid_d;
   logic [SETS-1:0]   dirty_q, dirty_d;
   logic [TAG_W-1:0]  tag_q [SETS];

   logic              wb_valid_q, wb_valid_d;
   logic [IDX_W-1:0]  wb_index_q, wb_index_d;
   logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
   logic [LINE_W-1:0] wb_data_q, wb_data_d;

   logic              busy;
   logic              clr_ptr;
   cache_way_cmd_t    cmd;
   logic [LINE_W-1:0] rd_data;
   logic [LINE_W-1:0] ptr_data;

   assign busy = (state_q != IDLE);

   // Access commands are masked for the whole sweep, DONE included
   always_comb begin
      cmd = '0;
      if (!busy) begin
         cmd.write_data  = bus.write_data;
         cmd.write_tag   = bus.write_tag;
         cmd.write_dirty = bus.write_dirty;
         cmd.inval_one   = bus.inval_one;
      end
   end

   way_bytewrite_array #(
      .SETS   (SETS),
      .LINE_W (LINE_W)
   ) u_data (
      .clk_i     (clk),
      .we_i      (cmd.write_data),
      .widx_i    (bus.index),
      .wdata_i   (bus.data_in),
      .wbe_i     (bus.byte_en),
      .ridx_a_i  (bus.index),
      .rdata_a_o (rd_data),
      .ridx_b_i  (ptr_q),
      .rdata_b_o (ptr_data)
   );

   // Tag store, no reset: valid qualifies it
   always_ff @(posedge clk) begin
      if (cmd.write_tag) begin
         tag_q[bus.index] <= bus.tag_in;
      end
   end

   // Flush sequencing plus capture/release of the write-back line
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      clr_ptr    = 1'b0;
      wb_valid_d = wb_valid_q;
      wb_index_d = wb_index_q;
      wb_tag_d   = wb_tag_q;
      wb_data_d  = wb_data_q;
      case (state_q)
         IDLE: begin
            if (bus.flush_req) begin
               state_d = SCAN;
               ptr_d   = '0;
            end
         end
         SCAN: begin
            if (valid_q[ptr_q] && dirty_q[ptr_q]) begin
               state_d    = WB;
               wb_valid_d = 1'b1;
               wb_index_d = ptr_q;
               wb_tag_d   = tag_q[ptr_q];
               wb_data_d  = ptr_data;
            end else begin
               clr_ptr = 1'b1;
               if (ptr_q == LAST_SET) begin
                  state_d = DONE;
               end else begin
                  ptr_d = ptr_q + IDX_W'(1);
               end
            end
         end
         WB: begin
            if (bus.wb_ack) begin
               clr_ptr    = 1'b1;
               wb_valid_d = 1'b0;
               if (ptr_q == LAST_SET) begin
                  state_d = DONE;
               end else begin
                  state_d = SCAN;
                  ptr_d   = ptr_q + IDX_W'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Valid/dirty update: write_tag wins over inval_one, inval_one wins over write_dirty
   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (cmd.write_dirty) begin
         dirty_d[bus.index] = bus.dirty_in;
      end
      if (cmd.inval_one) begin
         valid_d[bus.index] = 1'b0;
         dirty_d[bus.index] = 1'b0;
      end
      if (cmd.write_tag) begin
         valid_d[bus.index] = 1'b1;
      end
      if (clr_ptr) begin
         valid_d[ptr_q] = 1'b0;
         dirty_d[ptr_q] = 1'b0;
      end
   end

   // State, status bits and write-back registers; reset aborts any sweep
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         valid_q    <= '0;
         dirty_q    <= '0;
         wb_valid_q <= 1'b0;
         wb_index_q <= '0;
         wb_tag_q   <= '0;
         wb_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         valid_q    <= valid_d;
         dirty_q    <= dirty_d;
         wb_valid_q <= wb_valid_d;
         wb_index_q <= wb_index_d;
         wb_tag_q   <= wb_tag_d;
         wb_data_q  <= wb_data_d;
      end
   end

   assign bus.valid_out  = valid_q[bus.index];
   assign bus.dirty_out  = dirty_q[bus.index];
   assign bus.tag_out    = tag_q[bus.index];
   assign bus.data_out   = rd_data;
   assign bus.hit        = valid_q[bus.index] && (tag_q[bus.index] == bus.tag_in);
   assign bus.flush_busy = busy;
   assign bus.flush_done = (state_q == DONE);
   assign bus.wb_valid   = wb_valid_q;
   assign bus.wb_index   = wb_index_q;
   assign bus.wb_tag     = wb_tag_q;
   assign bus.wb_data    = wb_data_q;

endmodule

// File: tb/tb_cache_way_param.sv
// tb/tb_cache_way_param.sv - scoreboard bench for cache_way_param
module tb_cache_way_param;

   localparam int SETS   = 8;
   localparam int TAG_W  = 9;
   localparam int LINE_W = 128;
   localparam int BE_W   = LINE_W / 8;
   localparam int IDX_W  = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cache_way_param_if #(.SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) bus ();

   cache_way_param #(.SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic              m_valid [SETS];
   logic              m_dirty [SETS];
   logic [TAG_W-1:0]  m_tag   [SETS];
   logic [LINE_W-1:0] m_data  [SETS];

   typedef struct {
      int                idx;
      logic [TAG_W-1:0]  tag;
      logic [LINE_W-1:0] data;
   } wb_exp_t;

   wb_exp_t wb_q[$];
   int      ack_delay = 0;
   bit      ack_noise = 1'b0;
   int      hs_count  = 0;

   task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctrl();
      bus.write_data  = 1'b0;
      bus.write_tag   = 1'b0;
      bus.write_dirty = 1'b0;
      bus.inval_one   = 1'b0;
      bus.dirty_in    = 1'b0;
      bus.byte_en     = '0;
   endtask

   task automatic do_op(input bit wd, input bit wt, input bit wdy, input bit inv, input int idx,
                        input logic [TAG_W-1:0] tg, input logic [LINE_W-1:0] d,
                        input logic [BE_W-1:0] be, input bit din);
      bus.index       = IDX_W'(idx);
      bus.tag_in      = tg;
      bus.data_in     = d;
      bus.byte_en     = be;
      bus.write_data  = wd;
      bus.write_tag   = wt;
      bus.write_dirty = wdy;
      bus.inval_one   = inv;
      bus.dirty_in    = din;
      cyc();
      clear_ctrl();
      if (wd) begin
         for (int k = 0; k < BE_W; k++) begin
            if (be[k]) m_data[idx][8*k +: 8] = d[8*k +: 8];
         end
      end
      if (wt) m_tag[idx] = tg;
      if (wdy) m_dirty[idx] = din;
      if (inv) begin
         m_valid[idx] = 1'b0;
         m_dirty[idx] = 1'b0;
      end
      if (wt) m_valid[idx] = 1'b1;
   endtask

   task automatic read_check(input int idx, input logic [TAG_W-1:0] tg, input bit full);
      logic exp_hit;
      bus.index  = IDX_W'(idx);
      bus.tag_in = tg;
      #2;
      exp_hit = m_valid[idx] && (m_tag[idx] == tg);
      check($sformatf("valid[%0d]", idx), LINE_W'(bus.valid_out), LINE_W'(m_valid[idx]));
      check($sformatf("dirty[%0d]", idx), LINE_W'(bus.dirty_out), LINE_W'(m_dirty[idx]));
      check($sformatf("hit[%0d]", idx), LINE_W'(bus.hit), LINE_W'(exp_hit));
      if (full) begin
         check($sformatf("tag[%0d]", idx), LINE_W'(bus.tag_out), LINE_W'(m_tag[idx]));
         check($sformatf("data[%0d]", idx), bus.data_out, m_data[idx]);
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Expected sweep cost: one scan cycle per set, one DONE cycle, and delay+1 cycles per dirty line
   task automatic run_flush(input int delay, input bit noise, input bit blocked_ops);
      int ndirty   = 0;
      int busy_cyc = 0;
      int done_cnt = 0;
      int guard    = 0;
      bit done_last = 1'b0;
      for (int i = 0; i < SETS; i++) begin
         if (m_valid[i] && m_dirty[i]) begin
            wb_q.push_back('{idx: i, tag: m_tag[i], data: m_data[i]});
            ndirty++;
         end
      end
      hs_count  = 0;
      ack_delay = delay;
      ack_noise = noise;
      bus.flush_req = 1'b1;
      cyc();
      while (bus.flush_busy && guard < 400) begin
         busy_cyc++;
         guard++;
         if (bus.flush_done) done_cnt++;
         done_last = bus.flush_done;
         bus.flush_req = 1'($urandom_range(0, 1));
         if (blocked_ops) begin
            bus.index       = IDX_W'($urandom_range(0, SETS - 1));
            bus.tag_in      = TAG_W'($urandom);
            bus.data_in     = rand_line();
            bus.byte_en     = '1;
            bus.write_data  = 1'($urandom_range(0, 1));
            bus.write_tag   = 1'($urandom_range(0, 1));
            bus.write_dirty = 1'($urandom_range(0, 1));
            bus.inval_one   = 1'($urandom_range(0, 1));
            bus.dirty_in    = 1'b1;
         end
         cyc();
      end
      bus.flush_req = 1'b0;
      clear_ctrl();
      if (guard >= 400) begin
         checks++;
         errors++;
         $display("FAIL flush_timeout: got busy after %0d cycles expected end of sweep", guard);
      end
      check("flush_busy_cycles", LINE_W'(busy_cyc), LINE_W'(SETS + 1 + ndirty * (delay + 1)));
      check("flush_done_pulses", LINE_W'(done_cnt), LINE_W'(1));
      check("flush_done_last", LINE_W'(done_last), LINE_W'(1));
      check("wb_handshakes", LINE_W'(hs_count), LINE_W'(ndirty));
      check("wb_pending", LINE_W'(wb_q.size()), LINE_W'(0));
      wb_q.delete();
      cyc();
      check("busy_after_done", LINE_W'(bus.flush_busy), LINE_W'(0));
      for (int i = 0; i < SETS; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      for (int i = 0; i < SETS; i++) read_check(i, m_tag[i], 1'b1);
   endtask

   // Downstream acceptor: acks after ack_delay waiting cycles, optional ack noise outside write-back
   initial begin
      int cnt;
      cnt = 0;
      bus.wb_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            cnt = 0;
            bus.wb_ack = 1'b0;
         end else if (bus.wb_valid) begin
            if (cnt >= ack_delay) begin
               bus.wb_ack = 1'b1;
            end else begin
               bus.wb_ack = 1'b0;
               cnt++;
            end
         end else begin
            cnt = 0;
            bus.wb_ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
   end

   // Scoreboard monitor: every presented write-back line must match the head of the expected queue
   always @(negedge clk) begin
      if (rst_n && bus.wb_valid) begin
         if (wb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_unexpected: got index %0d expected no write-back", bus.wb_index);
         end else begin
            check("wb_index", LINE_W'(bus.wb_index), LINE_W'(wb_q[0].idx));
            check("wb_tag", LINE_W'(bus.wb_tag), LINE_W'(wb_q[0].tag));
            check("wb_data", bus.wb_data, wb_q[0].data);
            if (bus.wb_ack) begin
               void'(wb_q.pop_front());
               hs_count++;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      rst_n = 1'b0;
      clear_ctrl();
      bus.flush_req = 1'b0;
      bus.index     = '0;
      bus.tag_in    = '0;
      bus.data_in   = '0;
      for (int i = 0; i < SETS; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("reset_busy", LINE_W'(bus.flush_busy), LINE_W'(0));
      check("reset_done", LINE_W'(bus.flush_done), LINE_W'(0));
      check("reset_wb_valid", LINE_W'(bus.wb_valid), LINE_W'(0));
      check("reset_wb_index", LINE_W'(bus.wb_index), LINE_W'(0));
      cyc();
      for (int i = 0; i < SETS; i++) read_check(i, TAG_W'($urandom), 1'b0);

      for (int i = 0; i < SETS; i++) do_op(1, 1, 1, 0, i, TAG_W'($urandom), rand_line(), '1, 1'b0);
      for (int i = 0; i < SETS; i++) read_check(i, m_tag[i], 1'b1);

      do_op(0, 1, 0, 0, 3, 9'h1A5, '0, '0, 1'b0);
      do_op(1, 0, 0, 0, 3, '0, '1, 16'h00F0, 1'b0);
      read_check(3, 9'h1A5, 1'b1);
      check("partial_hit_match", LINE_W'(bus.hit), LINE_W'(1));
      check("partial_hi_bytes", LINE_W'(bus.data_out[63:32]), LINE_W'(32'hFFFF_FFFF));
      read_check(3, 9'h1A4, 1'b1);
      check("partial_hit_miss", LINE_W'(bus.hit), LINE_W'(0));

      run_flush(0, 1'b0, 1'b0);

      for (int i = 0; i < SETS; i++) do_op(0, 1, 1, 0, i, TAG_W'($urandom), '0, '0, (i == 2 || i == 7));
      run_flush(3, 1'b0, 1'b0);

      do_op(0, 1, 1, 1, 5, 9'h055, '0, '0, 1'b1);
      read_check(5, 9'h055, 1'b1);
      check("prio_tag_beats_inval", LINE_W'(bus.valid_out), LINE_W'(1));
      do_op(0, 0, 1, 1, 5, '0, '0, '0, 1'b1);
      read_check(5, 9'h055, 1'b1);
      check("prio_inval_beats_dirty", LINE_W'(bus.dirty_out), LINE_W'(0));

      for (int i = 0; i < SETS; i++) do_op(0, 1, 1, 0, i, TAG_W'($urandom), '0, '0, 1'($urandom_range(0, 1)));
      run_flush(1, 1'b1, 1'b1);

      for (int i = 0; i < SETS; i++) do_op(0, 1, 1, 0, i, TAG_W'($urandom), '0, '0, (i == 1 || i == 4));
      for (int i = 0; i < SETS; i++) begin
         if (m_valid[i] && m_dirty[i]) wb_q.push_back('{idx: i, tag: m_tag[i], data: m_data[i]});
      end
      ack_delay = 1000;
      ack_noise = 1'b0;
      bus.flush_req = 1'b1;
      cyc();
      bus.flush_req = 1'b0;
      guard = 0;
      while (!bus.wb_valid && guard < 50) begin
         guard++;
         cyc();
      end
      check("midflush_reached_wb", LINE_W'(bus.wb_valid), LINE_W'(1));
      rst_n = 1'b0;
      #2;
      check("midflush_wb_valid", LINE_W'(bus.wb_valid), LINE_W'(0));
      check("midflush_busy", LINE_W'(bus.flush_busy), LINE_W'(0));
      check("midflush_done", LINE_W'(bus.flush_done), LINE_W'(0));
      wb_q.delete();
      for (int i = 0; i < SETS; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      cyc();
      cyc();
      rst_n = 1'b1;
      ack_delay = 0;
      cyc();
      check("post_reset_busy", LINE_W'(bus.flush_busy), LINE_W'(0));
      for (int i = 0; i < SETS; i++) read_check(i, m_tag[i], 1'b1);

      for (int n = 0; n < 300; n++) begin
         int               idx;
         int               ridx;
         logic [BE_W-1:0]  be;
         logic [TAG_W-1:0] rtag;
         idx = $urandom_range(0, SETS - 1);
         case ($urandom_range(0, 3))
            0:       be = '0;
            1:       be = '1;
            default: be = BE_W'($urandom);
         endcase
         do_op(($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4),
               ($urandom_range(0, 9) < 2), idx, TAG_W'($urandom), rand_line(), be, 1'($urandom_range(0, 1)));
         ridx = $urandom_range(0, SETS - 1);
         rtag = $urandom_range(0, 1) ? m_tag[ridx] : TAG_W'($urandom);
         read_check(ridx, rtag, 1'b1);
         if (n % 75 == 74) run_flush($urandom_range(0, 3), 1'b1, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
